// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline types: controller state encoding and register-index width.
package pipeline_ctrl_pkg;

   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detection between the EX-stage load and the ID-stage sources.
module hazard_detect
   import pipeline_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rd,
   output logic             load_use
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = id_use_rs1 & (id_rs1 == ex_rd);
   assign rs2_hit = id_use_rs2 & (id_rs2 == ex_rd);

   // x0 is hardwired zero, so a load targeting it is never a hazard
   assign load_use = ex_mem_read & (ex_rd != '0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with MEM-stage timeout FSM and perf counters.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_enable,
   output logic             if_id_enable,
   output logic             id_ex_enable,
   output logic             ex_mem_enable,
   output logic             mem_wb_enable,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             bus_error,
   output logic [31:0]      stall_cycles,
   output logic [15:0]      flush_count
);

   localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] wait_cnt;
   logic [7:0] wait_nxt;
   logic       load_use;
   logic       freeze;

   hazard_detect u_hazard (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .load_use    (load_use)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      case (state)
         RUN: begin
            if (mem_req & ~mem_ready) begin
               state_nxt = MEM_WAIT;
               wait_nxt  = '0;
            end
         end
         MEM_WAIT: begin
            if (mem_ready) begin
               state_nxt = RUN;
               wait_nxt  = '0;
            end else begin
               wait_nxt = wait_cnt + 8'd1;
               if (wait_nxt == MAX_W) state_nxt = ERROR;
            end
         end
         ERROR: ;
         default: begin
            state_nxt = RUN;
            wait_nxt  = '0;
         end
      endcase
   end

   assign bus_error = (state == ERROR);
   assign freeze    = (mem_req & ~mem_ready) | bus_error;

   // Reset keeps everything enabled so the stage registers' own reset wins
   always_comb begin
      pc_enable     = 1'b1;
      if_id_enable  = 1'b1;
      id_ex_enable  = 1'b1;
      ex_mem_enable = 1'b1;
      mem_wb_enable = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      if (!reset) begin
         priority case (1'b1)
            freeze: begin
               pc_enable     = 1'b0;
               if_id_enable  = 1'b0;
               id_ex_enable  = 1'b0;
               ex_mem_enable = 1'b0;
               mem_wb_enable = 1'b0;
            end
            ex_branch_taken: begin
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
            end
            load_use: begin
               pc_enable    = 1'b0;
               if_id_enable = 1'b0;
               id_ex_flush  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (!pc_enable) stall_cycles <= stall_cycles + 32'd1;
         if (if_id_flush | id_ex_flush) flush_count <= flush_count + 16'd1;
      end
   end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, giving the maximum MEM-stage wait cycles before a bus error (range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports id_rs1 and id_rs2, input, 5 bits each, with id_use_rs1 and id_use_rs2, input, 1 bit each: ID-stage source registers and their valid flags.
REQ-005 SHALL have port ex_mem_read, input, 1 bit, and ex_rd, input, 5 bits: the EX-stage instruction is a load, and its destination.
REQ-006 SHALL have port ex_branch_taken, input, 1 bit: a branch or jump resolved taken in EX.
REQ-007 SHALL have port mem_req, input, 1 bit, and mem_ready, input, 1 bit: MEM-stage data-memory request and completion handshake.
REQ-008 SHALL have ports pc_enable, if_id_enable, id_ex_enable, ex_mem_enable and mem_wb_enable, output, 1 bit each: per-stage register enables.
REQ-009 SHALL have ports if_id_flush and id_ex_flush, output, 1 bit each: synchronous bubble insertion into IF/ID and ID/EX.
REQ-010 SHALL have port bus_error, output, 1 bit: sticky memory-timeout flag.
REQ-011 SHALL have port stall_cycles, output, 32 bits, and flush_count, output, 16 bits: performance counters.

Function
REQ-012 SHALL implement FSM states RUN, MEM_WAIT and ERROR.
REQ-013 In RUN, mem_req=1 with mem_ready=0 SHALL move to MEM_WAIT; all other combinations stay in RUN.
REQ-014 In MEM_WAIT, mem_ready=1 SHALL return to RUN; otherwise the wait counter SHALL increment, and reaching MAX_WAIT SHALL move to ERROR.
REQ-015 ERROR SHALL be terminal until reset, with bus_error=1.
REQ-016 freeze SHALL be (mem_req & ~mem_ready) or state==ERROR, evaluated combinationally in the current cycle.
REQ-017 freeze=1 SHALL drive all five enables to 0 and both flushes to 0; this has top priority.
REQ-018 Otherwise, ex_branch_taken=1 SHALL give all enables=1 and if_id_flush=id_ex_flush=1; branch overrides load-use.
REQ-019 Otherwise, load-use (ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))) SHALL give pc_enable=if_id_enable=0 and id_ex_flush=1, with the remaining enables=1.
REQ-020 Otherwise, all enables SHALL be 1 and all flushes 0.
REQ-021 A mem_ready arriving on the same cycle as mem_req SHALL cause zero stall cycles.
REQ-022 The wait counter SHALL clear on every entry to MEM_WAIT and on the return to RUN.
REQ-023 stall_cycles SHALL increment, wrapping at 2^32, on every cycle where pc_enable=0.
REQ-024 flush_count SHALL increment, wrapping at 2^16, on every cycle where if_id_flush or id_ex_flush is 1, by 1 regardless of how many are set.
REQ-025 Load-use detection SHALL never fire on ex_rd=0.

Reset
REQ-026 reset SHALL asynchronously force state=RUN, wait counter=0, bus_error=0, stall_cycles=0 and flush_count=0.
REQ-027 While reset=1, all enables SHALL be 1 and all flushes 0, so that the pipeline registers' own reset dominates.
REQ-028 Reset asserted mid-MEM_WAIT or in ERROR SHALL abandon the wait and come out of reset in RUN.

Structure
REQ-029 The state encoding (RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2) and the register-index width constant SHALL live in the shared pipeline package.
REQ-030 Hazard detection (REQ-019, REQ-025) SHALL be a combinational sub-module named hazard_detect; the FSM and counters SHALL stay in pipeline_ctrl.

Verification
REQ-031 Load with ex_rd=5 and id_rs1=5, id_use_rs1=1 -> one cycle with pc_enable=0, if_id_enable=0, id_ex_flush=1; stall_cycles=1.
REQ-032 ex_branch_taken=1 together with the load-use condition -> if_id_flush=id_ex_flush=1, pc_enable=1; flush_count=1.
REQ-033 mem_req=1 with mem_ready low for 3 cycles then high -> all enables 0 for exactly 3 cycles, state returns to RUN, stall_cycles=3.
REQ-034 mem_req=1 with mem_ready held low and MAX_WAIT=4 -> bus_error=1 after 5 cycles total; enables stay 0 until reset.
REQ-035 ex_rd=0 with id_rs1=0 and ex_mem_read=1 -> no stall.
REQ-036 Reset pulse during MEM_WAIT -> counters=0, state=RUN, enables=1 immediately and asynchronously.
